// File: rtl/sync_down_pkg.sv
// -----------------------------------------------------------------------------
// sync_down_pkg
//   Shared definitions for the sync_down_counter block.
//   - WIDTH_DEF : default counter width in bits
//   - state_t   : controller state encoding (IDLE / RUN / DONE); the code
//                 2'd3 is unused and is steered back to IDLE by the FSM.
// -----------------------------------------------------------------------------
package sync_down_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : sync_down_pkg

// File: rtl/dcnt_core.sv
// -----------------------------------------------------------------------------
// dcnt_core
//   Datapath of the down counter: count register Q, reload register RLD,
//   decrement, reload and zero detect. All sequencing decisions come from the
//   controller in the top level through the strobes below.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears Q and RLD)
//   i_ld     in   load strobe: Q <= i_d and RLD <= i_d
//   i_d      in   load value
//   i_dec    in   decrement strobe: Q <= Q - 1
//   i_reload in   terminal-count reload strobe: Q <= RLD
//   o_q      out  registered count value
//   o_zero   out  combinational Q == 0
// -----------------------------------------------------------------------------
module dcnt_core
  import sync_down_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_dec,
  input  logic             i_reload,
  output logic [WIDTH-1:0] o_q,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rld;
  logic [WIDTH-1:0] w_q_dec;

  // Plain modulo-2^WIDTH decrement; the controller never requests it at
  // zero, so the all-ones wrap never reaches the register.
  assign w_q_dec = r_q - WIDTH'(1);

  // Load wins over everything; reload and decrement are mutually exclusive
  // by construction (one needs Q==0, the other Q!=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_rld <= '0;
    end else if (i_ld) begin
      r_q   <= i_d;
      r_rld <= i_d;
    end else if (i_reload) begin
      r_q   <= r_rld;
    end else if (i_dec) begin
      r_q   <= w_q_dec;
    end
  end

  assign o_q    = r_q;
  assign o_zero = (r_q == '0);

endmodule : dcnt_core

// File: rtl/sync_down_counter.sv
// -----------------------------------------------------------------------------
// sync_down_counter
//   Loadable synchronous down counter with one-shot / auto-reload modes.
//   The top level holds the IDLE/RUN/DONE controller, the DONE flag register
//   and the borrow-out; the count datapath lives in dcnt_core.
//
// Ports
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   EN    in   count enable
//   LD    in   synchronous load strobe (priority over EN), any state -> RUN
//   D     in   load / reload value
//   MODE  in   0 = one-shot, 1 = auto-reload; looked at on terminal count
//   Q     out  registered count value
//   BO    out  combinational borrow-out: RUN & EN & Q==0 & ~LD
//   DONE  out  registered, high while the controller is in DONE
// -----------------------------------------------------------------------------
module sync_down_counter
  import sync_down_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             DONE
);

  state_t r_state;
  state_t w_state_nxt;
  logic   r_done;

  logic   w_run;
  logic   w_zero;
  logic   w_cnt_en;
  logic   w_tc;
  logic   w_dec;
  logic   w_reload;

  // Counting only happens in RUN with no load pending; a terminal count is
  // an enabled cycle that finds Q already at zero.
  assign w_run    = (r_state == S_RUN);
  assign w_cnt_en = w_run & EN & ~LD;
  assign w_tc     = w_cnt_en & w_zero;
  assign w_dec    = w_cnt_en & ~w_zero;
  assign w_reload = w_tc & MODE;

  assign BO = w_tc;

  dcnt_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_ld     (LD),
    .i_d      (D),
    .i_dec    (w_dec),
    .i_reload (w_reload),
    .o_q      (Q),
    .o_zero   (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // DONE is registered from the next state so it tracks the state
      // register exactly, including being cleared by the exiting load.
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (LD) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // One-shot terminal count parks in DONE with Q held at zero;
        // auto-reload stays in RUN while the core reloads Q from RLD.
        if (LD)                w_state_nxt = S_RUN;
        else if (w_tc & ~MODE) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (LD) w_state_nxt = S_RUN;
      end
      default: begin
        // The unused code recovers to IDLE. A simultaneous load still goes
        // to RUN because the datapath captures D on LD regardless of state.
        w_state_nxt = LD ? S_RUN : S_IDLE;
      end
    endcase
  end

  assign DONE = r_done;

endmodule : sync_down_counter

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  // Reference-model states (abstract, not the RTL encoding)
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         EN    = 1'b0;
  logic         LD    = 1'b0;
  logic         MODE  = 1'b0;
  logic [W-1:0] D     = '0;
  logic [W-1:0] Q;
  logic         BO;
  logic         DONE;

  sync_down_counter #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .EN    (EN),
    .LD    (LD),
    .D     (D),
    .MODE  (MODE),
    .Q     (Q),
    .BO    (BO),
    .DONE  (DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int done;
    int bo;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: count value, reload value, phase
  int mq   = 0;
  int mrld = 0;
  int ms   = M_IDLE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the rules of the counter.
  task automatic model_edge(input int ld, input int d, input int en, input int mode);
    if (ld != 0) begin
      mq   = d & MASK;
      mrld = d & MASK;
      ms   = M_RUN;
    end else if (ms == M_RUN && en != 0) begin
      if (mq != 0)        mq = (mq - 1) & MASK;
      else if (mode != 0) mq = mrld;
      else                ms = M_DONE;
    end
  endtask

  // Drive one cycle of stimulus just after the edge, record what the DUT
  // must show before the next edge, then advance the model across it.
  task automatic step(input int ld, input int d, input int en, input int mode);
    exp_t e;
    @(posedge clk);
    #1;
    LD   = (ld != 0);
    D    = d[W-1:0];
    EN   = (en != 0);
    MODE = (mode != 0);
    e.q    = mq;
    e.done = (ms == M_DONE) ? 1 : 0;
    e.bo   = (ms == M_RUN && en != 0 && mq == 0 && ld == 0) ? 1 : 0;
    sb.push_back(e);
    model_edge(ld, d, en, mode);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    chk("pre_rst_Q", Q, mq);
    LD    = 1'b0;
    EN    = 1'b1;
    rst_n = 1'b0;
    #1;
    mq   = 0;
    mrld = 0;
    ms   = M_IDLE;
    chk("rst_Q", Q, 0);
    chk("rst_DONE", DONE, 0);
    chk("rst_BO", BO, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every cycle with an outstanding expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("Q", Q, e.q);
      chk("DONE", DONE, e.done);
      chk("BO", BO, e.bo);
    end
  end

  initial begin
    int r;
    int wait_cyc;

    // Power-up reset
    #1;
    chk("init_Q", Q, 0);
    chk("init_DONE", DONE, 0);
    chk("init_BO", BO, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-count, then EN without LD keeps Q at 0
    step(1, 5, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    do_reset();
    repeat (3) step(0, 0, 1, 0);

    // One-shot from 3
    step(1, 3, 0, 0);
    repeat (10) step(0, 0, 1, 0);

    // Auto-reload from 2
    step(1, 2, 0, 1);
    repeat (8) step(0, 0, 1, 1);

    // Hold at 6, then load beats enable
    step(1, 8, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 9, 1, 0);
    step(0, 0, 1, 0);

    // Load of zero: immediate terminal count
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Full range from 15 with no wrap
    step(1, 15, 0, 0);
    repeat (18) step(0, 0, 1, 0);

    // Exit DONE by load
    step(1, 4, 0, 0);
    repeat (3) step(0, 0, 1, 0);

    // Auto-reload with RLD = 0: BO on every enabled cycle
    step(1, 0, 0, 1);
    repeat (4) step(0, 0, 1, 1);

    // Randomized traffic
    repeat (500) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else begin
        step((r < 12) ? 1 : 0,
             $urandom_range(0, MASK),
             ($urandom_range(0, 3) != 0) ? 1 : 0,
             $urandom_range(0, 1));
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    n_tests++;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sync_down_counter

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 EN  input  1  count enable; sampled on posedge clk.
REQ-005 LD  input  1  synchronous load strobe; has priority over EN.
REQ-006 D  input  WIDTH  load value; also captured as reload value.
REQ-007 MODE  input  1  0 = one-shot, 1 = auto-reload; sampled at terminal count.
REQ-008 Q  output  WIDTH  registered count value.
REQ-009 BO  output  1  combinational borrow-out, for cascading.
REQ-010 DONE  output  1  registered; high while in DONE state.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; reset state is IDLE.
REQ-012 LD=1 in any state at posedge SHALL set Q<=D and RLD<=D, then go to RUN; EN is ignored that cycle.
REQ-013 IDLE and DONE, with LD=0, SHALL hold Q and ignore EN.
REQ-014 RUN, LD=0, EN=0 SHALL hold Q and RLD.
REQ-015 RUN, LD=0, EN=1, Q!=0 SHALL set Q<=Q-1, modulo 2^WIDTH arithmetic, latency one edge.
REQ-016 RUN, LD=0, EN=1, Q==0, MODE=0 SHALL go to DONE with Q held at 0; no underflow to all-ones.
REQ-017 RUN, LD=0, EN=1, Q==0, MODE=1 SHALL set Q<=RLD and stay in RUN.
REQ-018 BO SHALL equal (state==RUN) & EN & (Q==0) & ~LD, with no register delay.
REQ-019 DONE SHALL be 1 exactly when state==DONE; it is cleared by the LD that exits DONE.
REQ-020 A load of D=0 SHALL enter RUN with Q=0, so the next enabled cycle is a terminal count.
REQ-021 RLD=0 in auto-reload mode SHALL assert BO on every enabled cycle while Q stays 0.

Reset
REQ-022 rst_n=0 SHALL, without waiting for clk, force Q=0, RLD=0, state=IDLE and DONE=0; BO then evaluates to 0.
REQ-023 Reset asserted mid-count SHALL abandon the count; counting resumes only after a new LD.
REQ-024 Deassertion of rst_n SHALL take effect at the first posedge clk with rst_n=1.

Structure
REQ-025 Package sync_down_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-026 Sub-module dcnt_core SHALL hold the Q/RLD datapath registers, the decrement, reload and zero-detect logic.
REQ-027 The top level SHALL hold the FSM, the DONE register and the BO logic.
REQ-028 Unused encoding 2'd3 SHALL transition to IDLE.

Verification (WIDTH=4)
REQ-029 Async reset: LD D=5, EN=1 for 2 edges (Q=3), then pull rst_n low between edges -> Q=0, DONE=0 immediately, state IDLE; a later EN=1 without LD keeps Q=0.
REQ-030 One-shot: LD D=3, MODE=0, then EN=1 held -> Q=3,2,1,0 on successive edges; BO=1 only during the Q=0 cycle; next edge DONE=1 and Q stays 0 for 5 more edges.
REQ-031 Auto-reload: LD D=2, MODE=1, EN=1 held -> Q=2,1,0,2,1,0,2; BO pulses every 3rd cycle; DONE never asserts.
REQ-032 Priority and hold: in RUN at Q=6, EN=0 for 3 edges -> Q=6; then LD=1 with D=9 and EN=1 on the same edge -> Q=9, not 8, and BO=0 that cycle.
REQ-033 Boundaries: LD D=0, MODE=0, EN=1 -> BO=1 that cycle, DONE=1 next edge. LD D=15, MODE=0, EN=1 -> 15 edges reach Q=0, the 16th edge enters DONE, and Q never wraps to 15.
REQ-034 Exit DONE: in DONE, apply LD D=4 -> DONE=0 and Q=4 at that edge, counting resumes.
